fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the CPU controller and decode path.
- Holds the fetch PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Buffers returned 16-bit instructions in a small queue and presents them to decode with a valid/ready handshake.
- Exposes opcode bits [15:12] as id_op for the controller; redirects on the controller's pcsrc (branch taken).

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_queue.sv | 64 ++++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants used by the fetch stage.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned PC_STEP = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small instruction FIFO between fetch and decode; flush overrides push and pop.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = INSTR_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [W-1:0]                   push_pc,
    input  logic [W-1:0]                   push_instr,
    input  logic                           pop,
    input  logic                           flush,
    output logic [$clog2(DEPTH + 1)-1:0]   count,
    output logic [W-1:0]                   head_pc,
    output logic [W-1:0]                   head_instr
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  pc_mem    [DEPTH];
    logic [W-1:0]  instr_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request FSM and decode-side queue.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned   n        = 16,
    parameter int unsigned   QDEPTH   = 2,
    parameter logic [n-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [n-1:0] imem_rdata,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    input  logic         id_ready,
    output logic         id_valid,
    output logic [n-1:0] id_instr,
    output logic [n-1:0] id_pc,
    output logic [3:0]   id_op
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [n-1:0]  pc;
    logic [n-1:0]  pc_nxt;
    logic [n-1:0]  req_addr;
    logic [n-1:0]  req_addr_nxt;
    logic          stale;
    logic          stale_nxt;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    logic          room_idle;
    logic          room_resp;

    // A slot is reserved when a request is issued, so room is judged after this cycle's pop.
    assign pop             = id_valid & id_ready;
    assign count_after_pop = count - CW'(pop);
    assign room_idle       = count_after_pop < CW'(QDEPTH);
    assign room_resp       = count_after_pop < CW'(QDEPTH - 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            stale    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            stale    <= stale_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        stale_nxt    = stale;
        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end else if (room_idle) begin
                    req_addr_nxt = pc;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                // A request redirected before its grant is still granted at the old address; drop it.
                if (imem_gnt) begin
                    stale_nxt = 1'b0;
                    if (redirect) begin
                        pc_nxt    = redirect_pc;
                        state_nxt = DROP;
                    end else if (stale) begin
                        state_nxt = DROP;
                    end else begin
                        pc_nxt    = pc + n'(PC_STEP);
                        state_nxt = RESP;
                    end
                end else if (redirect) begin
                    pc_nxt    = redirect_pc;
                    stale_nxt = 1'b1;
                end
            end
            RESP: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        pc_nxt    = redirect_pc;
                        state_nxt = IDLE;
                    end else if (room_resp) begin
                        req_addr_nxt = pc;
                        state_nxt    = REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        push     = 1'b0;
        case (state)
            REQ:     imem_req = 1'b1;
            RESP:    push     = imem_rvalid & ~redirect;
            default: ;
        endcase
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .W     (n)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_pc    (req_addr),
        .push_instr (imem_rdata),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_pc    (id_pc),
        .head_instr (id_instr)
    );

    assign imem_addr = req_addr;
    assign id_valid  = (count != '0);
    assign id_op     = id_instr[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency/grant-controllable memory model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [3:0]  id_op;

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          lat       = 1;
    int          gnt_wait  = 0;
    int          pend_cnt  = 0;
    bit          pend_act  = 0;
    logic [15:0] pend_data = '0;

    logic [15:0] gnt_log[$];
    logic [15:0] acc_pc[$];
    logic [15:0] acc_instr[$];
    logic [3:0]  acc_op[$];

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_op       (id_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0002: return 16'h5678;
            default:  return a ^ 16'h9000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Log the pop the next edge will perform, then drive memory inputs at the falling edge.
    task automatic tick();
        if (reset && !redirect && id_valid && id_ready) begin
            acc_pc.push_back(id_pc);
            acc_instr.push_back(id_instr);
            acc_op.push_back(id_op);
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
        if (pend_act) begin
            if (pend_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_data;
                pend_act    = 0;
            end else begin
                pend_cnt--;
            end
        end
        imem_gnt = 1'b0;
        if (imem_req) begin
            if (gnt_wait > 0) begin
                gnt_wait--;
            end else begin
                imem_gnt  = 1'b1;
                gnt_log.push_back(imem_addr);
                pend_act  = 1;
                pend_cnt  = lat;
                pend_data = word(imem_addr);
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        gnt_wait = 0;
        lat      = 1;
        tick();
        tick();
        pend_act = 0;
        gnt_log.delete();
        acc_pc.delete();
        acc_instr.delete();
        acc_op.delete();
        reset = 1'b1;
    endtask

    task automatic wait_gnts(input int want, input string tag);
        int k = 0;
        while (gnt_log.size() < want && k < 60) begin
            tick();
            k++;
        end
        if (gnt_log.size() < want) check({tag, "_gnt_timeout"}, 32'(gnt_log.size()), 32'(want));
    endtask

    task automatic wait_accs(input int want, input string tag);
        int k = 0;
        while (acc_pc.size() < want && k < 60) begin
            tick();
            k++;
        end
        if (acc_pc.size() < want) check({tag, "_acc_timeout"}, 32'(acc_pc.size()), 32'(want));
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        // Reset state
        do_reset();
        check("rst_req",   imem_req,  0);
        check("rst_valid", id_valid,  0);
        check("rst_addr",  imem_addr, 16'h0000);

        // Sequential fetch with immediate grant, 1-cycle data
        id_ready = 1'b1;
        wait_accs(2, "seq");
        check("seq_addr0", gnt_log[0], 16'h0000);
        check("seq_addr1", gnt_log[1], 16'h0002);
        check("seq_op0",   acc_op[0],  4'h1);
        check("seq_op1",   acc_op[1],  4'h5);
        check("seq_pc0",   acc_pc[0],  16'h0000);
        check("seq_pc1",   acc_pc[1],  16'h0002);

        // Decode stalled: queue fills to two, fetch stops
        do_reset();
        repeat (8) tick();
        check("full_req",    imem_req,               0);
        check("full_valid",  id_valid,               1);
        check("full_grants", 32'(gnt_log.size()),    2);
        check("full_pc",     id_pc,                  16'h0000);
        check("full_op",     id_op,                  4'h1);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("pop_req",  imem_req,  1);
        check("pop_addr", imem_addr, 16'h0004);
        check("pop_pc",   id_pc,     16'h0002);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check("flush_valid", id_valid, 0);

        // Redirect in RESP before the data returns
        do_reset();
        id_ready = 1'b1;
        lat      = 3;
        tick();
        tick();
        pend_data   = 16'hDEAD;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        lat      = 1;
        check("rresp_req",   imem_req, 0);
        check("rresp_valid", id_valid, 0);
        wait_gnts(2, "rresp");
        check("rresp_addr", gnt_log[1], 16'h0040);
        wait_accs(1, "rresp");
        check("rresp_instr", acc_instr[0], 16'h9040);
        check("rresp_pc",    acc_pc[0],    16'h0040);

        // Redirect in REQ while grant is withheld
        do_reset();
        id_ready = 1'b1;
        gnt_wait = 3;
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        tick();
        redirect = 1'b0;
        check("rreq_hold0", imem_addr, 16'h0000);
        tick();
        check("rreq_hold1", imem_addr, 16'h0000);
        check("rreq_req",   imem_req,  1);
        wait_gnts(2, "rreq");
        check("rreq_addr0", gnt_log[0], 16'h0000);
        check("rreq_addr1", gnt_log[1], 16'h0080);
        wait_accs(1, "rreq");
        check("rreq_instr", acc_instr[0], 16'h9080);
        check("rreq_pc",    acc_pc[0],    16'h0080);

        // Reset pulse while a response is pending
        do_reset();
        id_ready = 1'b1;
        lat      = 4;
        tick();
        tick();
        pend_data = 16'hDEAD;
        gnt_wait  = 3;
        reset     = 1'b0;
        tick();
        reset = 1'b1;
        lat   = 1;
        check("mrst_req",   imem_req,  0);
        check("mrst_valid", id_valid,  0);
        check("mrst_addr",  imem_addr, 16'h0000);
        wait_gnts(2, "mrst");
        check("mrst_addr1", gnt_log[1], 16'h0000);
        wait_accs(1, "mrst");
        check("mrst_instr", acc_instr[0], 16'h1234);
        check("mrst_pc",    acc_pc[0],    16'h0000);

        // PC wrap at top of address space
        do_reset();
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        wait_gnts(2, "wrap");
        check("wrap_addr0", gnt_log[0], 16'hFFFE);
        check("wrap_addr1", gnt_log[1], 16'h0000);
        wait_accs(2, "wrap");
        check("wrap_pc0", acc_pc[0], 16'hFFFE);
        check("wrap_pc1", acc_pc[1], 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
